radix2_mul: RTL and testbench

- Sequential radix-2 shift-add multiplier; the counterpart of the radix-2 divider in the arithmetic unit.
- Accepts two WIDTH-bit operands through a valid/ready handshake and retires one product bit-step per clock.
- Returns a 2*WIDTH-bit product held under a valid/ready handshake until the consumer takes it.
- Supports unsigned and two's-complement signed operands, selected per operation.

---
 rtl/radix2_mul.sv | 134 +++++++++++++
 tb/tb_radix2_mul.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/radix2_mul.sv
// radix2_mul: sequential radix-2 shift-add multiplier.
//
// Takes two WIDTH-bit operands, unsigned or two's-complement signed (chosen
// per operation by 'sign'). It retires one multiplier bit per clock and
// returns a 2*WIDTH-bit product.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   sign         1 = signed operands, 0 = unsigned (sampled with operands)
//   multiplicand operand A (WIDTH bits)
//   multiplier   operand B (WIDTH bits)
//   opn_valid    operands offered
//   opn_ready    block can accept operands (IDLE only)
//   res_ready    consumer takes the result
//   res_valid    result is valid (DONE only)
//   result       product (2*WIDTH bits), holds its last value after handoff
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer must hold valid until that edge, and the data
// must be stable while valid is high. Ready never depends on valid.
// opn_ready depends only on state. res_valid and result are held stable in
// DONE for as long as res_ready stays low.
//
// Assumes WIDTH >= 2.

module radix2_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sign,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 opn_valid,
  output logic                 opn_ready,
  input  logic                 res_ready,
  output logic                 res_valid,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod_final;

  assign accept    = (state == IDLE) && opn_valid;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // Datapath combinational helpers
  always_comb begin
    mag_a = multiplicand;
    mag_b = multiplier;
    // The most negative value negates to itself. Read as unsigned, that
    // bit pattern is exactly its magnitude, 2^(WIDTH-1).
    if (sign && multiplicand[WIDTH-1]) mag_a = -multiplicand;
    if (sign && multiplier[WIDTH-1])   mag_b = -multiplier;

    // Add into the upper half and keep the carry as bit WIDTH. The
    // following right shift then pulls that carry back into the accumulator.
    upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_nxt   = {upper_sum, acc[WIDTH-1:1]};

    prod_final = neg ? -acc_nxt : acc_nxt;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (opn_valid) state_nxt = BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    opn_ready = (state == IDLE);
    res_valid = (state == DONE);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= mag_a;
      mplier <= mag_b;
      cnt    <= '0;
      neg    <= sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
    end else if (state == BUSY) begin
      acc    <= acc_nxt;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last_iter) result <= prod_final;
    end
  end

endmodule

// File: tb/tb_radix2_mul.sv
// Directed testbench for radix2_mul (WIDTH = 8). It drives inputs 1 time
// unit after each rising edge and samples outputs at the same point.

module tb_radix2_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        sign;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        opn_valid;
  logic        opn_ready;
  logic        res_ready;
  logic        res_valid;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  radix2_mul #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sign         (sign),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .opn_valid    (opn_valid),
    .opn_ready    (opn_ready),
    .res_ready    (res_ready),
    .res_valid    (res_valid),
    .result       (result)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until res_valid is high, with a bounded wait.
  task automatic wait_result(output int n);
    n = 0;
    while (!res_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  // One complete operation with res_ready held high.
  task automatic run_op(input string tag, input logic s, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp);
    int n;
    check({tag, "_ready_before"}, opn_ready, 1);
    sign = s; multiplicand = a; multiplier = b;
    opn_valid = 1'b1; res_ready = 1'b1;
    step();
    opn_valid = 1'b0;
    // Operands may change freely after acceptance
    multiplicand = 8'($urandom_range(0, 255));
    multiplier   = 8'($urandom_range(0, 255));
    sign         = 1'($urandom_range(0, 1));
    check({tag, "_busy_ready"}, opn_ready, 0);
    wait_result(n);
    check({tag, "_latency"}, n, 8);
    check({tag, "_result"}, result, exp);
    step();
    check({tag, "_valid_drop"}, res_valid, 0);
    check({tag, "_idle_ready"}, opn_ready, 1);
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    int n;
    rst = 1'b1; sign = 1'b0; multiplicand = '0; multiplier = '0;
    opn_valid = 1'b0; res_ready = 1'b0;
    #1;
    check("reset_opn_ready", opn_ready, 1);
    check("reset_res_valid", res_valid, 0);
    check("reset_result", result, 0);
    step(); step();
    rst = 1'b0;
    step();

    // Unsigned and signed directed vectors
    run_op("u200x3",    1'b0, 8'd200, 8'd3,  16'h0258);
    run_op("s_m5x7",    1'b1, 8'hFB,  8'h07, 16'hFFDD);
    run_op("s_80x7f",   1'b1, 8'h80,  8'h7F, 16'hC080);
    run_op("s_80x80",   1'b1, 8'h80,  8'h80, 16'h4000);
    run_op("u_80x80",   1'b0, 8'h80,  8'h80, 16'h4000);
    run_op("u_ffxff",   1'b0, 8'hFF,  8'hFF, 16'hFE01);
    run_op("s_ffxff",   1'b1, 8'hFF,  8'hFF, 16'h0001);
    run_op("s_0xm1",    1'b1, 8'h00,  8'hFF, 16'h0000);
    run_op("u_0x9a",    1'b0, 8'h00,  8'h9A, 16'h0000);

    // Backpressure: hold res_ready low for 5 cycles after res_valid
    sign = 1'b1; multiplicand = 8'hFB; multiplier = 8'h07;
    opn_valid = 1'b1; res_ready = 1'b0;
    step();
    opn_valid = 1'b0;
    wait_result(n);
    check("bp_latency", n, 8);
    check("bp_result", result, 16'hFFDD);
    for (int i = 0; i < 5; i++) begin
      // A new operand pulse in the middle must be ignored
      if (i == 2) begin
        opn_valid = 1'b1; sign = 1'b0; multiplicand = 8'd9; multiplier = 8'd9;
      end else begin
        opn_valid = 1'b0;
      end
      step();
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_result", result, 16'hFFDD);
      check("bp_hold_opn_ready", opn_ready, 0);
    end
    opn_valid = 1'b0;
    res_ready = 1'b1;
    step();
    check("bp_release_valid", res_valid, 0);
    check("bp_release_ready", opn_ready, 1);
    check("bp_release_result", result, 16'hFFDD);
    step();
    check("bp_no_ghost_op", opn_ready, 1);

    // Reset three cycles into BUSY
    sign = 1'b0; multiplicand = 8'd200; multiplier = 8'd3; opn_valid = 1'b1;
    step();
    opn_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("rst_mid_res_valid", res_valid, 0);
    check("rst_mid_result", result, 0);
    check("rst_mid_opn_ready", opn_ready, 1);
    step();
    rst = 1'b0;
    step();
    check("rst_after_valid", res_valid, 0);
    run_op("u12x12", 1'b0, 8'd12, 8'd12, 16'h0090);

    // Back-to-back with opn_valid and res_ready held high
    sign = 1'b0; multiplicand = 8'd200; multiplier = 8'd3;
    opn_valid = 1'b1; res_ready = 1'b1;
    step();
    sign = 1'b1; multiplicand = 8'hFB; multiplier = 8'h07;
    wait_result(n);
    check("b2b_first_latency", n, 8);
    check("b2b_first_result", result, 16'h0258);
    n = 0;
    do begin
      step();
      n++;
      if (n == 2) opn_valid = 1'b0;
    end while (!res_valid && n < 40);
    check("b2b_spacing", n, 10);
    check("b2b_second_result", result, 16'hFFDD);
    step();
    check("b2b_end_valid", res_valid, 0);
    check("b2b_end_ready", opn_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
